tmp_seq_ctrl: RTL

- Parametrised successor to the single-channel temperature-sensor sequencer.
- Drives the switched-capacitor front end through precharge, bias-trim setup and an oversampled charge-balancing conversion; phase lengths and oversampling ratio are parameters.
- Multiplexes NCH sensor channels round-robin and returns a per-channel ones-count code over a valid/ready handshake.
- Sits between the analog front end (switch phases, comparator) and the digital readout.

---
 rtl/tmp_seq_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/tmp_seq_ctrl.sv
// rtl/tmp_seq_ctrl.sv - multi-channel temperature-sensor front-end sequencer with charge-balancing conversion
module tmp_seq_ctrl #(
    parameter int NCH        = 2,
    parameter int PRE_CYC    = 26,
    parameter int SETUP_ITER = 5,
    parameter int SETUP_CYC  = 6,
    parameter int BIG_CYC    = 11,
    parameter int DIO_CYC    = 8,
    parameter int CHG_CYC    = 6,
    parameter int OSR        = 16,
    parameter int TRIM_W     = 4,
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int CODE_W    = $clog2(OSR) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cmp,
    output logic              busy,
    output logic [CH_W-1:0]   ch_sel,
    output logic              pre_chrg,
    output logic              setup_bias,
    output logic              pi1,
    output logic              pi2,
    output logic              pii1,
    output logic              pii2,
    output logic              pa,
    output logic              pb,
    output logic              pc,
    output logic              pd,
    output logic              s_bg2cmp,
    output logic              cmp_p1,
    output logic              cmp_p2,
    output logic [TRIM_W-1:0] bias_trim,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    input  logic              code_ready
);

    typedef enum logic [3:0] {
        IDLE, PRECHARGE, SETUP, BLANK, BIGDIODE, DIODE, CHARGE, SMPLCMP, OUTPUT
    } state_t;

    localparam logic [TRIM_W-1:0] TRIM_MID = TRIM_W'(1) << (TRIM_W - 1);

    state_t            state, state_nxt;
    state_t            blank_tgt, blank_tgt_nxt;   // phase that follows the current BLANK
    logic [15:0]       cnt;
    logic [15:0]       iter;
    logic [CODE_W-1:0] acc;
    logic [CODE_W-1:0] acc_inc;
    logic              dec;
    logic              abort_go;
    logic              trim_tick;
    logic              setup_last;
    logic              conv_last;
    logic              last_ch;

    assign busy       = (state != IDLE);
    assign cmp_p2     = ~cmp_p1;
    assign acc_inc    = acc + CODE_W'(cmp);
    assign trim_tick  = (state == SETUP) && (cnt == 16'(SETUP_CYC - 1));
    assign setup_last = trim_tick && (iter == 16'(SETUP_ITER - 1));
    assign conv_last  = (iter == 16'(OSR - 1));
    assign last_ch    = (ch_sel == CH_W'(NCH - 1));
    // A BLANK already heading to IDLE is not re-armed by a held abort
    assign abort_go   = abort && (state != IDLE) && !(state == BLANK && blank_tgt == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            blank_tgt <= IDLE;
        end else begin
            state     <= state_nxt;
            blank_tgt <= blank_tgt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        blank_tgt_nxt = blank_tgt;
        pre_chrg      = 1'b0;
        setup_bias    = 1'b0;
        pi1           = 1'b0;
        pi2           = 1'b0;
        pii1          = 1'b0;
        pii2          = 1'b0;
        pa            = 1'b0;
        pb            = 1'b0;
        pc            = 1'b0;
        pd            = 1'b0;
        s_bg2cmp      = 1'b0;
        code_valid    = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = PRECHARGE;
            PRECHARGE: begin
                pre_chrg   = 1'b1;
                setup_bias = 1'b1;
                s_bg2cmp   = 1'b1;
                pb         = 1'b1;
                pc         = 1'b1;
                pd         = 1'b1;
                if (cnt == 16'(PRE_CYC - 1)) state_nxt = SETUP;
            end
            SETUP: begin
                setup_bias = 1'b1;
                pi1        = 1'b1;
                pi2        = 1'b1;
                if (setup_last) begin
                    state_nxt     = BLANK;
                    blank_tgt_nxt = BIGDIODE;
                end
            end
            BLANK: state_nxt = blank_tgt;
            BIGDIODE: begin
                pi1 = 1'b1;
                pi2 = 1'b1;
                if (cnt == 16'(BIG_CYC - 1)) begin
                    state_nxt     = BLANK;
                    blank_tgt_nxt = DIODE;
                end
            end
            DIODE: begin
                pii1 = 1'b1;
                pii2 = 1'b1;
                if (cnt == 16'(DIO_CYC - 1)) begin
                    state_nxt     = BLANK;
                    blank_tgt_nxt = CHARGE;
                end
            end
            CHARGE: begin
                pa       = 1'b1;
                s_bg2cmp = 1'b1;
                pb       = ~dec;
                pc       = dec;
                if (cnt == 16'(CHG_CYC - 1)) state_nxt = SMPLCMP;
            end
            SMPLCMP: begin
                if (conv_last) begin
                    state_nxt = OUTPUT;
                end else begin
                    state_nxt     = BLANK;
                    blank_tgt_nxt = BIGDIODE;
                end
            end
            OUTPUT: begin
                code_valid = 1'b1;
                if (code_ready) begin
                    if (last_ch) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt     = BLANK;
                        blank_tgt_nxt = BIGDIODE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort_go) begin
            state_nxt     = BLANK;
            blank_tgt_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            iter      <= '0;
            acc       <= '0;
            dec       <= 1'b0;
            ch_sel    <= '0;
            bias_trim <= TRIM_MID;
            code      <= '0;
            cmp_p1    <= 1'b1;
        end else begin
            cnt <= ((state_nxt != state) || trim_tick) ? 16'd0 : cnt + 16'd1;
            if (abort_go) begin
                iter   <= '0;
                acc    <= '0;
                dec    <= 1'b0;
                ch_sel <= '0;
            end else begin
                case (state)
                    PRECHARGE: if (state_nxt == SETUP) cmp_p1 <= ~cmp_p1;
                    SETUP: if (trim_tick) begin
                        if (cmp) begin
                            if (bias_trim != '0) bias_trim <= bias_trim - TRIM_W'(1);
                        end else begin
                            if (bias_trim != '1) bias_trim <= bias_trim + TRIM_W'(1);
                        end
                        iter <= setup_last ? 16'd0 : iter + 16'd1;
                        if (setup_last) dec <= 1'b0;
                    end
                    SMPLCMP: begin
                        dec    <= cmp;
                        acc    <= acc_inc;
                        cmp_p1 <= ~cmp_p1;
                        iter   <= conv_last ? 16'd0 : iter + 16'd1;
                        if (conv_last) code <= acc_inc;
                    end
                    OUTPUT: if (code_ready) begin
                        acc    <= '0;
                        dec    <= 1'b0;
                        ch_sel <= last_ch ? '0 : ch_sel + CH_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
